// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic int fetch_clog2(input int value);
    int result;
    result = 0;
    while ((32'sd1 <<< result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fetch_checker.sv
// Protocol checker for the fetch imem port: a response must never arrive with nothing outstanding.
module fetch_checker (
  input logic i_clk,
  input logic i_rst,
  input logic i_imem_req,
  input logic i_imem_gnt,
  input logic i_imem_rvalid
);

  logic [7:0] outst_r;

  // Requests granted but not yet answered, as seen on the port
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      outst_r <= 8'd0;
    end else begin
      outst_r <= outst_r + {7'd0, i_imem_req & i_imem_gnt} - {7'd0, i_imem_rvalid};
    end
  end

  a_no_orphan_rvalid: assert property (@(posedge i_clk) disable iff (i_rst)
    i_imem_rvalid |-> (outst_r != 8'd0));

endmodule

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with push/pop/clear, occupancy count and head view.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = fetch_clog2(DEPTH + 1),
  localparam int IDX_W = (DEPTH > 1) ? fetch_clog2(DEPTH) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clear,
  input  logic               i_push,
  input  fetch_entry_t       i_push_data,
  input  logic               i_pop,
  output fetch_entry_t       o_head,
  output logic [CNT_W-1:0]   o_count
);

  fetch_entry_t     mem_r [DEPTH];
  logic [IDX_W-1:0] rd_ptr_r;
  logic [IDX_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] ptr);
    if (ptr == IDX_W'(DEPTH - 1)) begin
      return {IDX_W{1'b0}};
    end else begin
      return ptr + IDX_W'(1);
    end
  endfunction

  // Qualify push/pop against full/empty
  always_comb begin
    push_ok_s = i_push & (count_r != CNT_W'(DEPTH));
    pop_ok_s  = i_pop & (count_r != {CNT_W{1'b0}});
  end

  // Pointer and occupancy bookkeeping; clear wins over push/pop
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr_r <= {IDX_W{1'b0}};
      wr_ptr_r <= {IDX_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (i_clear) begin
      rd_ptr_r <= {IDX_W{1'b0}};
      wr_ptr_r <= {IDX_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop_ok_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only meaningful below count_r
  always_ff @(posedge i_clk) begin
    if (push_ok_s && !i_clear) mem_r[wr_ptr_r] <= i_push_data;
  end

  assign o_head  = mem_r[rd_ptr_r];
  assign o_count = count_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests, buffers returned
// words with their PC and presents them downstream. FETCH_PERF_CNT_EN adds o_bubble_cnt.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FBUF_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_ready,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc_plus_4,
  output logic        o_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] o_bubble_cnt
`endif
);

  localparam int CNT_W = fetch_clog2(FBUF_DEPTH + 1);

  logic [31:0]      pc_r;
  logic [CNT_W-1:0] drop_r;
  logic [CNT_W-1:0] tag_count_s;
  logic [CNT_W-1:0] buf_count_s;
  fetch_entry_t     tag_push_s;
  fetch_entry_t     tag_head_s;
  fetch_entry_t     buf_push_s;
  fetch_entry_t     buf_head_s;
  logic [CNT_W:0]   outstanding_s;
  logic [CNT_W+1:0] occupancy_s;
  logic             req_s;
  logic             grant_s;
  logic             have_drop_s;
  logic             rsp_take_s;
  logic             push_s;
  logic             pop_s;
  logic             buf_valid_s;
  logic             drop_dec_s;
  logic [CNT_W-1:0] drop_next_s;
  logic [31:0]      pc_next_s;

  // Issue gating, response routing and next-state for PC / drop count
  always_comb begin
    outstanding_s = {1'b0, drop_r} + {1'b0, tag_count_s};
    occupancy_s   = {1'b0, outstanding_s} + {2'b00, buf_count_s};
    buf_valid_s   = (buf_count_s != {CNT_W{1'b0}});
    have_drop_s   = (drop_r != {CNT_W{1'b0}});
    if (i_rst || i_redirect) begin
      req_s = 1'b0;
    end else begin
      req_s = (occupancy_s < (CNT_W + 2)'(FBUF_DEPTH));
    end
    grant_s    = req_s & i_imem_gnt;
    // Stale responses are consumed by the drop count before any tag is matched
    rsp_take_s = i_imem_rvalid & ~have_drop_s & (tag_count_s != {CNT_W{1'b0}});
    push_s     = rsp_take_s & ~i_redirect;
    pop_s      = buf_valid_s & i_ready & ~i_redirect;
    drop_dec_s = i_imem_rvalid & (outstanding_s != {(CNT_W + 1){1'b0}});
    tag_push_s       = tag_head_s;
    tag_push_s.pc    = pc_r;
    tag_push_s.instr = 32'h0000_0000;
    buf_push_s       = tag_head_s;
    buf_push_s.instr = i_imem_rdata;
    if (i_redirect) begin
      drop_next_s = CNT_W'(outstanding_s - {{CNT_W{1'b0}}, drop_dec_s});
      pc_next_s   = i_redirect_pc & 32'hFFFF_FFFC;
    end else begin
      drop_next_s = (i_imem_rvalid && have_drop_s) ? (drop_r - CNT_W'(1)) : drop_r;
      pc_next_s   = grant_s ? (pc_r + 32'd4) : pc_r;
    end
  end

  // PC and stale-response drop count
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_r   <= RESET_PC;
      drop_r <= {CNT_W{1'b0}};
    end else begin
      pc_r   <= pc_next_s;
      drop_r <= drop_next_s;
    end
  end

  fetch_fifo #(.DEPTH(FBUF_DEPTH)) u_tag_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (i_redirect),
    .i_push      (grant_s),
    .i_push_data (tag_push_s),
    .i_pop       (rsp_take_s),
    .o_head      (tag_head_s),
    .o_count     (tag_count_s)
  );

  fetch_fifo #(.DEPTH(FBUF_DEPTH)) u_buf_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (i_redirect),
    .i_push      (push_s),
    .i_push_data (buf_push_s),
    .i_pop       (pop_s),
    .o_head      (buf_head_s),
    .o_count     (buf_count_s)
  );

  assign o_imem_req    = req_s;
  assign o_imem_addr   = pc_r;
  assign o_valid       = buf_valid_s;
  assign o_pc          = buf_valid_s ? buf_head_s.pc : 32'h0000_0000;
  assign o_instruction = buf_valid_s ? buf_head_s.instr : NOP_INSTR;
  assign o_pc_plus_4   = o_pc + 32'd4;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] bubble_cnt_r;

  // Cycles where downstream was ready but nothing was presented
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bubble_cnt_r <= 32'd0;
    end else if (!buf_valid_s && i_ready) begin
      bubble_cnt_r <= bubble_cnt_r + 32'd1;
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

  assign o_bubble_cnt = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency in-order instruction memory model.
module tb_fetch_unit;

  logic        i_clk;
  logic        i_rst;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_ready;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_pc;
  logic [31:0] o_instruction;
  logic [31:0] o_pc_plus_4;
  logic        o_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] o_bubble_cnt;
`endif

  int          total;
  int          bad;
  bit          resp_en;
  logic [31:0] pend[$];
  logic [31:0] exp_pc;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FBUF_DEPTH(3)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_ready       (i_ready),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_pc          (o_pc),
    .o_instruction (o_instruction),
    .o_pc_plus_4   (o_pc_plus_4),
    .o_valid       (o_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_bubble_cnt  (o_bubble_cnt)
`endif
  );

  fetch_checker u_chk (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_imem_req    (o_imem_req),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: record grants, then answer the oldest pending request after the edge
  task automatic tick();
    @(negedge i_clk);
    if (o_imem_req === 1'b1 && i_imem_gnt === 1'b1) pend.push_back(o_imem_addr);
    @(posedge i_clk);
    #1;
    if (i_rst) begin
      pend.delete();
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = 32'h0000_0000;
    end else if (resp_en && pend.size() > 0) begin
      i_imem_rdata  = mem_word(pend.pop_front());
      i_imem_rvalid = 1'b1;
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = 32'h0000_0000;
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (o_valid !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
  endtask

  initial begin
    total = 0;
    bad = 0;
    resp_en = 1'b1;
    i_rst = 1'b1;
    i_redirect = 1'b0;
    i_redirect_pc = 32'h0000_0000;
    i_ready = 1'b1;
    i_imem_gnt = 1'b1;
    i_imem_rvalid = 1'b0;
    i_imem_rdata = 32'h0000_0000;
    tick();
    tick();

    // reset state
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_pc", o_pc, 32'h0000_0000);
    check("rst_instr", o_instruction, 32'h0000_0013);
    check("rst_pc4", o_pc_plus_4, 32'h0000_0004);
    check("rst_req", {31'd0, o_imem_req}, 32'd0);

    // 1: streaming fetch, consecutive after a two-cycle fill
    i_rst = 1'b0;
    #1;
    check("t1_req", {31'd0, o_imem_req}, 32'd1);
    check("t1_addr", o_imem_addr, 32'h0000_0000);
    tick();
    check("t1_latency", {31'd0, o_valid}, 32'd0);
    tick();
    for (int k = 0; k < 6; k++) begin
      check("t1_valid", {31'd0, o_valid}, 32'd1);
      check("t1_pc", o_pc, 32'(4 * k));
      check("t1_instr", o_instruction, mem_word(32'(4 * k)));
      check("t1_pc4", o_pc_plus_4, 32'(4 * k + 4));
      tick();
    end

    // 2: backpressure fills the buffer, request stops, resume without gap or duplicate
    i_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t2_hold_pc", o_pc, 32'h0000_0018);
      check("t2_req_off", {31'd0, o_imem_req}, 32'd0);
    end
    i_ready = 1'b1;
    exp_pc = 32'h0000_001C;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t2_resume_pc", o_pc, exp_pc);
      check("t2_resume_instr", o_instruction, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end

    // 3: redirect with two requests outstanding, stale responses dropped
    resp_en = 1'b0;
    tick();
    check("t3_pc44", o_pc, 32'h0000_002C);
    tick();
    check("t3_empty", {31'd0, o_valid}, 32'd0);
    i_redirect = 1'b1;
    i_redirect_pc = 32'h0000_0103;
    #1;
    check("t3_req_gated", {31'd0, o_imem_req}, 32'd0);
    tick();
    i_redirect = 1'b0;
    resp_en = 1'b1;
    #1;
    check("t3_after_valid", {31'd0, o_valid}, 32'd0);
    check("t3_addr", o_imem_addr, 32'h0000_0100);
    wait_valid("t3");
    check("t3_pc", o_pc, 32'h0000_0100);
    check("t3_instr", o_instruction, mem_word(32'h0000_0100));
    tick();
    check("t3_pc_next", o_pc, 32'h0000_0104);
    tick();
    check("t3_pc_next2", o_pc, 32'h0000_0108);

    // 4: redirect in the same cycle as rvalid and ready
    check("t4_rvalid_now", {31'd0, i_imem_rvalid}, 32'd1);
    i_redirect = 1'b1;
    i_redirect_pc = 32'h0000_0200;
    #1;
    check("t4_req_gated", {31'd0, o_imem_req}, 32'd0);
    tick();
    i_redirect = 1'b0;
    check("t4_valid_off", {31'd0, o_valid}, 32'd0);
    wait_valid("t4");
    check("t4_pc", o_pc, 32'h0000_0200);
    check("t4_instr", o_instruction, mem_word(32'h0000_0200));

    // 5: PC wrap at the top of the address space
    i_redirect = 1'b1;
    i_redirect_pc = 32'hFFFF_FFFC;
    tick();
    i_redirect = 1'b0;
    wait_valid("t5");
    check("t5_pc", o_pc, 32'hFFFF_FFFC);
    check("t5_pc4", o_pc_plus_4, 32'h0000_0000);
    check("t5_instr", o_instruction, mem_word(32'hFFFF_FFFC));
    tick();
    check("t5_wrap_pc", o_pc, 32'h0000_0000);
    check("t5_wrap_instr", o_instruction, mem_word(32'h0000_0000));

    // 6: asynchronous reset mid-stream, then restart
    #2;
    i_rst = 1'b1;
    #1;
    check("t6_valid", {31'd0, o_valid}, 32'd0);
    check("t6_pc", o_pc, 32'h0000_0000);
    check("t6_instr", o_instruction, 32'h0000_0013);
    check("t6_pc4", o_pc_plus_4, 32'h0000_0004);
    check("t6_req", {31'd0, o_imem_req}, 32'd0);
    tick();
    i_rst = 1'b0;
    i_imem_gnt = 1'b0;
    #1;
    check("t6_restart_addr", o_imem_addr, 32'h0000_0000);
    for (int k = 0; k < 3; k++) tick();
    check("t6_starved", {31'd0, o_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("t6_bubbles", o_bubble_cnt, 32'd3);
`endif
    i_imem_gnt = 1'b1;
    wait_valid("t6");
    check("t6_first_pc", o_pc, 32'h0000_0000);
    check("t6_first_instr", o_instruction, mem_word(32'h0000_0000));
    tick();
    check("t6_second_pc", o_pc, 32'h0000_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
